axilite_read_addr: RTL and testbench
====================================

Name: axilite_read_addr

Overview:
- AXI4-Lite read-address (AR) channel front end. Sits directly upstream of the read-data stage.
- Accepts one AR handshake at a time and converts ARADDR into a byte offset relative to BASE_ADDR.
- Presents the offset as addr/addr_good to the read-data stage and blocks new addresses until that stage's R beat has left.
- Enforces exactly one outstanding read.

Parameters:
- ADDR_SIZE, 32, width of araddr and addr.
- DATA_WIDTH, 32, AXI-Lite data width in bits; must be a power of two of at least 8.
- BASE_ADDR, 0, byte address of offset 0; subtracted from araddr.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- araddr  input  ADDR_SIZE  AXI AR address
- arprot  input  3  AXI AR protection; accepted and ignored
- arvalid  input  1  AXI AR valid
- arready  output  1  AXI AR ready (registered)
- addr  output  ADDR_SIZE  byte offset to read-data stage (registered)
- addr_good  output  1  offset valid, to read-data stage (registered)
- deassert_addr  input  1  read-data stage acknowledge of addr
- rvalid  input  1  R-channel valid, monitored from read-data stage
- rready  input  1  R-channel ready, monitored from master
- busy  output  1  high whenever state is not IDLE (combinational from state)

Behaviour:
- Reset (async, any time, including mid-transaction):
  - state=IDLE, arready=1, addr_good=0, addr=0, busy=0.
  - Any in-flight read is abandoned; no handshake is replayed after reset.
- States: IDLE, PEND, WAIT_R.
- IDLE: arready=1, addr_good=0.
  - Edge with arvalid=1: addr <= araddr - BASE_ADDR (modulo 2^ADDR_SIZE, wrap allowed), addr_good<=1, arready<=0, go PEND.
  - arvalid=0: stay.
- PEND: arready=0, addr_good=1, addr stable.
  - Edge with deassert_addr=1: addr_good<=0, go WAIT_R.
  - Otherwise hold; addr_good never drops without deassert_addr.
- WAIT_R: arready=0, addr_good=0.
  - Edge with rvalid=0, or rvalid=1 and rready=1: arready<=1, go IDLE.
  - rvalid=1 and rready=0: stay.
- Latency:
  - AR handshake edge to addr_good high: 1 cycle.
  - Minimum AR-to-AR spacing: 3 cycles (IDLE→PEND→WAIT_R→IDLE).
- araddr < BASE_ADDR wraps to a large offset; the downstream range check rejects it. This block does no range check.
- arvalid held high while not in IDLE: ignored, no capture. The held address is accepted in the first IDLE cycle.
- araddr changes while arready=0: no effect on addr.
- arprot has no effect in any state.

Optional Feature:
- Macro: AXILITE_ADDR_ALIGN_EN.
- Defined: the captured offset is forced word-aligned. The low log2(DATA_WIDTH/8) bits of (araddr - BASE_ADDR) are cleared before registering. A DATA_WIDTH=32 read at offset 0x6 presents addr=0x4.
- Undefined: the offset is passed unmodified (addr=0x6). Misaligned offsets go to the read-data stage as-is.

Test Plan:
- Reset then idle: rst pulse, arvalid=0 for 5 cycles -> arready=1, addr_good=0, addr=0, busy=0 throughout.
- Basic read, BASE_ADDR=0x1000: araddr=0x1008 with arvalid=1 for 1 cycle; deassert_addr follows addr_good; rvalid=1 for 1 cycle with rready=1 -> next cycle addr=0x8, addr_good=1, arready=0; one cycle later addr_good=0; next edge arready=1. AR-to-arready spacing is exactly 3 cycles.
- Backpressure: as above but rready=0 for 4 cycles while rvalid held 1 -> state stays WAIT_R, arready=0, busy=1; arready=1 one cycle after rready=1.
- Back-to-back: arvalid held 1 with araddr=0x1000 then 0x1004 -> second address is captured only in the cycle after arready returns to 1; addr_good never high for two consecutive transactions without a low gap.
- Wrap: BASE_ADDR=0x1000, araddr=0x0FFC -> addr=0xFFFFFFFC, addr_good=1.
- Reset mid-PEND: rst asserted while addr_good=1 -> addr_good=0 and arready=1 immediately (asynchronous); after release, a new araddr=0x1010 is captured normally. With AXILITE_ADDR_ALIGN_EN, araddr=0x1006 gives addr=0x4; without it, addr=0x6.

Source files
------------

// File: rtl/axilite_read_addr_if.sv
// AXI4-Lite AR channel plus read-data stage handoff, grouped for axilite_read_addr.
// master: the AXI master / read-data stage side; slave: the axilite_read_addr block.
interface axilite_read_addr_if #(
  parameter int ADDR_SIZE = 32
);
  logic [ADDR_SIZE-1:0] araddr;
  logic [2:0]           arprot;
  logic                 arvalid;
  logic                 arready;
  logic [ADDR_SIZE-1:0] addr;
  logic                 addr_good;
  logic                 deassert_addr;
  logic                 rvalid;
  logic                 rready;
  logic                 busy;

  modport master (
    output araddr, arprot, arvalid, deassert_addr, rvalid, rready,
    input  arready, addr, addr_good, busy
  );

  modport slave (
    input  araddr, arprot, arvalid, deassert_addr, rvalid, rready,
    output arready, addr, addr_good, busy
  );
endinterface

// File: rtl/axilite_read_addr.sv
// AXI4-Lite read-address front end: one outstanding read, araddr rebased to BASE_ADDR.
// Optional AXILITE_ADDR_ALIGN_EN clears the sub-word bits of the captured offset.
//
// state  | meaning
// IDLE   | arready high, waiting for an AR handshake
// PEND   | offset presented on addr/addr_good, waiting for deassert_addr
// WAIT_R | offset taken, waiting for the R beat to leave
module axilite_read_addr #(
  parameter int                   ADDR_SIZE  = 32,
  parameter int                   DATA_WIDTH = 32,
  parameter logic [ADDR_SIZE-1:0] BASE_ADDR  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  axilite_read_addr_if.slave   bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] PEND   = 2'd1;
  localparam logic [1:0] WAIT_R = 2'd2;

  if (DATA_WIDTH < 8 || (DATA_WIDTH & (DATA_WIDTH - 1)) != 0) begin : g_bad_width
    $error("axilite_read_addr: DATA_WIDTH must be a power of two of at least 8");
  end

  logic [1:0]           state;
  logic [ADDR_SIZE-1:0] offset;
  logic [ADDR_SIZE-1:0] offset_cap;
  logic                 unused_arprot;

  // Subtraction wraps on purpose; out-of-range offsets are rejected downstream.
  assign offset = bus.araddr - BASE_ADDR;

`ifdef AXILITE_ADDR_ALIGN_EN
  localparam int                   ALIGN_BITS = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_SIZE-1:0] ALIGN_MASK = {ADDR_SIZE{1'b1}} << ALIGN_BITS;
  assign offset_cap = offset & ALIGN_MASK;
`else
  assign offset_cap = offset;
`endif

  assign unused_arprot = ^bus.arprot;
  assign bus.busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bus.arready   <= 1'b1;
      bus.addr_good <= 1'b0;
      bus.addr      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.arvalid) begin
            bus.addr      <= offset_cap;
            bus.addr_good <= 1'b1;
            bus.arready   <= 1'b0;
            state         <= PEND;
          end
        end
        PEND: begin
          if (bus.deassert_addr) begin
            bus.addr_good <= 1'b0;
            state         <= WAIT_R;
          end
        end
        WAIT_R: begin
          // Release only once no R beat is stalled at the master.
          if (!bus.rvalid || bus.rready) begin
            bus.arready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          bus.arready   <= 1'b1;
          bus.addr_good <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axilite_read_addr.sv
// Self-checking bench for axilite_read_addr: directed scenarios then random traffic,
// all checked against a transaction-level model of the one-outstanding-read rule.
module tb_axilite_read_addr;
  localparam int          ADDR_SIZE  = 32;
  localparam int          DATA_WIDTH = 32;
  localparam logic [31:0] BASE_ADDR  = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst = 1'b0;

  axilite_read_addr_if #(.ADDR_SIZE(ADDR_SIZE)) bus ();

  axilite_read_addr #(
    .ADDR_SIZE (ADDR_SIZE),
    .DATA_WIDTH(DATA_WIDTH),
    .BASE_ADDR (BASE_ADDR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: an offset is either presented (m_have), handed off and awaiting its
  // R beat (m_rpend), or nothing is outstanding and a new read may be accepted.
  bit          m_have  = 1'b0;
  bit          m_rpend = 1'b0;
  logic [31:0] m_addr  = '0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] offset_of(logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
`ifdef AXILITE_ADDR_ALIGN_EN
    off = off - (off % (DATA_WIDTH / 8));
`endif
    return off;
  endfunction

  task automatic check_all();
    check("arready",   {31'b0, bus.arready},   {31'b0, !(m_have || m_rpend)});
    check("addr_good", {31'b0, bus.addr_good}, {31'b0, m_have});
    check("busy",      {31'b0, bus.busy},      {31'b0, (m_have || m_rpend)});
    check("addr",      bus.addr,               m_addr);
  endtask

  task automatic drive(logic av, logic [31:0] a, logic da, logic rv, logic rr);
    bus.arvalid       = av;
    bus.araddr        = a;
    bus.arprot        = 3'($urandom);
    bus.deassert_addr = da;
    bus.rvalid        = rv;
    bus.rready        = rr;
  endtask

  task automatic step();
    @(posedge clk);
    if (!m_have && !m_rpend) begin
      if (bus.arvalid) begin
        m_addr = offset_of(bus.araddr);
        m_have = 1'b1;
      end
    end else if (m_have) begin
      if (bus.deassert_addr) begin
        m_have  = 1'b0;
        m_rpend = 1'b1;
      end
    end else if (!(bus.rvalid && !bus.rready)) begin
      m_rpend = 1'b0;
    end
    #1 check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_have  = 1'b0;
    m_rpend = 1'b0;
    m_addr  = '0;
    #1 check_all();
    @(posedge clk);
    #1 check_all();
    rst = 1'b0;
  endtask

  task automatic finish_txn();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    repeat (2) step();
  endtask

  initial begin
    int n;
    logic [31:0] exp_misaligned;

    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #2;
    do_reset();

    // Reset then idle
    repeat (5) step();

    // Basic read with AR-to-arready spacing
    drive(1'b1, 32'h1008, 1'b0, 1'b0, 1'b0);
    step();
    check("basic_addr", bus.addr, 32'h8);
    check("basic_good", {31'b0, bus.addr_good}, 32'h1);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    n = 1;
    while (!bus.arready && n < 10) begin
      step();
      n++;
    end
    check("ar_spacing", n, 3);

    // Backpressure in WAIT_R
    drive(1'b1, 32'h1004, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp_arready", {31'b0, bus.arready}, 32'h0);
      check("bp_busy",    {31'b0, bus.busy},    32'h1);
    end
    bus.rready = 1'b1;
    step();
    check("bp_release", {31'b0, bus.arready}, 32'h1);

    // Back-to-back with arvalid held
    drive(1'b1, 32'h1000, 1'b1, 1'b0, 1'b0);
    step();
    check("b2b_first", bus.addr, 32'h0);
    bus.araddr = 32'h1004;
    step();
    check("b2b_gap1", {31'b0, bus.addr_good}, 32'h0);
    step();
    check("b2b_gap2", {31'b0, bus.addr_good}, 32'h0);
    step();
    check("b2b_second", bus.addr, 32'h4);
    finish_txn();

    // Wrap below BASE_ADDR
    drive(1'b1, 32'h0FFC, 1'b0, 1'b0, 1'b0);
    step();
    check("wrap_addr", bus.addr, 32'hFFFF_FFFC);
    check("wrap_good", {31'b0, bus.addr_good}, 32'h1);
    finish_txn();

    // Reset mid-PEND, then normal capture
    drive(1'b1, 32'h1020, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_async_good",    {31'b0, bus.addr_good}, 32'h0);
    check("rst_async_arready", {31'b0, bus.arready},   32'h1);
    do_reset();
    drive(1'b1, 32'h1010, 1'b0, 1'b0, 1'b0);
    step();
    check("post_rst_addr", bus.addr, 32'h10);
    finish_txn();

    // Misaligned offset
`ifdef AXILITE_ADDR_ALIGN_EN
    exp_misaligned = 32'h4;
`else
    exp_misaligned = 32'h6;
`endif
    drive(1'b1, 32'h1006, 1'b0, 1'b0, 1'b0);
    step();
    check("misaligned_addr", bus.addr, exp_misaligned);
    finish_txn();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) == 0) ? $urandom : BASE_ADDR + 32'($urandom_range(0, 255));
      drive(1'($urandom), a, 1'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 299) == 0)
        do_reset();
      else
        step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
